// File: rtl/mem_intf_arbiter_nport.sv
// mem_intf_arbiter_nport: N-client to 1-server memory arbiter with tag-routed responses
module mem_intf_arbiter_nport #(
    parameter int p_num_ports = 2,
    parameter int p_opaq_bits = 8,
    parameter int p_msg_bits  = 74,
    parameter int p_rsp_bits  = 39,
    parameter int p_max_out   = 4,
    parameter int p_rr        = 1,
    localparam int p_id_bits  = $clog2(p_num_ports),
    localparam int p_cnt_bits = $clog2(p_max_out + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_num_ports-1:0]              cli_req_val,
    output logic [p_num_ports-1:0]              cli_req_rdy,
    input  logic [p_num_ports*p_opaq_bits-1:0]  cli_req_opaque,
    input  logic [p_num_ports*p_msg_bits-1:0]   cli_req_msg,
    output logic [p_num_ports-1:0]              cli_resp_val,
    input  logic [p_num_ports-1:0]              cli_resp_rdy,
    output logic [p_opaq_bits-1:0]              cli_resp_opaque,
    output logic [p_rsp_bits-1:0]               cli_resp_msg,
    output logic                                mem_req_val,
    input  logic                                mem_req_rdy,
    output logic [p_id_bits+p_opaq_bits-1:0]    mem_req_opaque,
    output logic [p_msg_bits-1:0]               mem_req_msg,
    input  logic                                mem_resp_val,
    output logic                                mem_resp_rdy,
    input  logic [p_id_bits+p_opaq_bits-1:0]    mem_resp_opaque,
    input  logic [p_rsp_bits-1:0]               mem_resp_msg
);
    typedef enum logic {REQ_EMPTY, REQ_FULL} req_state_t;
    req_state_t                 state, state_next;
    logic [p_id_bits-1:0]       ptr, start, win_id, j, rsp_id;
    logic                       win_any, can_load, req_fire, rsp_id_ok;
    logic [p_num_ports-1:0]     elig;
    logic [p_cnt_bits-1:0]      out_cnt [p_num_ports];

    assign start       = (p_rr != 0) ? ptr : '0;
    assign can_load    = (state == REQ_EMPTY) || mem_req_rdy;
    assign req_fire    = |cli_req_rdy;
    assign mem_req_val = (state == REQ_FULL);
    assign rsp_id      = mem_resp_opaque[p_id_bits+p_opaq_bits-1 -: p_id_bits];
    assign rsp_id_ok   = {1'b0, rsp_id} < (p_id_bits+1)'(p_num_ports);
    assign cli_resp_opaque = mem_resp_opaque[p_opaq_bits-1:0];
    assign cli_resp_msg    = mem_resp_msg;

    // Clients below their outstanding limit compete; search starts at the RR pointer (or 0)
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        j       = '0;
        for (int i = 0; i < p_num_ports; i++)
            elig[i] = cli_req_val[i] && (out_cnt[i] < p_cnt_bits'(p_max_out));
        for (int k = 0; k < p_num_ports; k++) begin
            j = p_id_bits'((int'(start) + k) % p_num_ports);
            if (!win_any && elig[j]) begin
                win_any = 1'b1;
                win_id  = j;
            end
        end
    end

    // Only the winner sees ready, and only when the output register can accept
    always_comb begin
        cli_req_rdy = '0;
        if (!rst && can_load && win_any) cli_req_rdy[win_id] = 1'b1;
    end

    // Output register occupancy: fills on a grant, empties when memory takes it
    always_comb begin
        state_next = req_fire ? REQ_FULL : (mem_req_rdy ? REQ_EMPTY : state);
    end

    // Occupancy and round-robin pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ_EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (req_fire) ptr <= (int'(win_id) == p_num_ports - 1) ? '0 : win_id + p_id_bits'(1);
        end
    end

    // Capture the granted request, tagging the opaque with its port id
    always_ff @(posedge clk) begin
        if (req_fire) begin
            mem_req_opaque <= {win_id, cli_req_opaque[win_id*p_opaq_bits +: p_opaq_bits]};
            mem_req_msg    <= cli_req_msg[win_id*p_msg_bits +: p_msg_bits];
        end
    end

    // Route responses by tag; unknown tags are swallowed so memory never stalls on them
    always_comb begin
        cli_resp_val = '0;
        mem_resp_rdy = 1'b1;
        for (int i = 0; i < p_num_ports; i++)
            if (rsp_id == p_id_bits'(i)) begin
                cli_resp_val[i] = mem_resp_val;
                mem_resp_rdy    = cli_resp_rdy[i];
            end
    end

    // Per-client outstanding counters; simultaneous issue and return cancel out
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_ports; i++)
            if (rst) out_cnt[i] <= '0;
            else if (cli_req_rdy[i] && cli_req_val[i] && !(cli_resp_val[i] && cli_resp_rdy[i]))
                out_cnt[i] <= out_cnt[i] + p_cnt_bits'(1);
            else if (!(cli_req_rdy[i] && cli_req_val[i]) && cli_resp_val[i] && cli_resp_rdy[i] && out_cnt[i] != '0)
                out_cnt[i] <= out_cnt[i] - p_cnt_bits'(1);
    end

`ifndef SYNTHESIS
    // Flag responses with impossible tags or with no matching outstanding request
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_resp_val && !rsp_id_ok) $error("arbiter: response tag %0d out of range", rsp_id);
            for (int i = 0; i < p_num_ports; i++)
                if (cli_resp_val[i] && cli_resp_rdy[i] && !(cli_req_rdy[i] && cli_req_val[i]) && out_cnt[i] == '0)
                    $error("arbiter: response to port %0d with nothing outstanding", i);
        end
    end
`endif
endmodule

// File: tb/tb_mem_intf_arbiter_nport.sv
// tb_mem_intf_arbiter_nport: directed checks of arbitration, backpressure, tagging and limits
module tb_mem_intf_arbiter_nport;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   cli_req_val, cli_resp_rdy;
    logic [31:0]  cli_req_opaque;
    logic [295:0] cli_req_msg;
    logic         mem_req_rdy, mem_resp_val;
    logic [9:0]   mem_resp_opaque;
    logic [38:0]  mem_resp_msg;
    logic [3:0]   cli_req_rdy_a, cli_resp_val_a, cli_req_rdy_b, cli_resp_val_b;
    logic [7:0]   cli_resp_opaque_a, cli_resp_opaque_b;
    logic [38:0]  cli_resp_msg_a, cli_resp_msg_b;
    logic         mem_req_val_a, mem_req_val_b, mem_resp_rdy_a, mem_resp_rdy_b;
    logic [9:0]   mem_req_opaque_a, mem_req_opaque_b;
    logic [73:0]  mem_req_msg_a, mem_req_msg_b;
    logic [73:0]  m [4];
    logic [9:0]   exp_opq [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_intf_arbiter_nport #(.p_num_ports(4), .p_max_out(2), .p_rr(1)) dut_a (
        .clk(clk), .rst(rst),
        .cli_req_val(cli_req_val), .cli_req_rdy(cli_req_rdy_a),
        .cli_req_opaque(cli_req_opaque), .cli_req_msg(cli_req_msg),
        .cli_resp_val(cli_resp_val_a), .cli_resp_rdy(cli_resp_rdy),
        .cli_resp_opaque(cli_resp_opaque_a), .cli_resp_msg(cli_resp_msg_a),
        .mem_req_val(mem_req_val_a), .mem_req_rdy(mem_req_rdy),
        .mem_req_opaque(mem_req_opaque_a), .mem_req_msg(mem_req_msg_a),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy_a),
        .mem_resp_opaque(mem_resp_opaque), .mem_resp_msg(mem_resp_msg)
    );

    mem_intf_arbiter_nport #(.p_num_ports(4), .p_max_out(15), .p_rr(0)) dut_b (
        .clk(clk), .rst(rst),
        .cli_req_val(cli_req_val), .cli_req_rdy(cli_req_rdy_b),
        .cli_req_opaque(cli_req_opaque), .cli_req_msg(cli_req_msg),
        .cli_resp_val(cli_resp_val_b), .cli_resp_rdy(4'hF),
        .cli_resp_opaque(cli_resp_opaque_b), .cli_resp_msg(cli_resp_msg_b),
        .mem_req_val(mem_req_val_b), .mem_req_rdy(mem_req_rdy),
        .mem_req_opaque(mem_req_opaque_b), .mem_req_msg(mem_req_msg_b),
        .mem_resp_val(1'b0), .mem_resp_rdy(mem_resp_rdy_b),
        .mem_resp_opaque(10'h0), .mem_resp_msg(39'h0)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m[0] = {10'h0, 32'h0000_0100, 32'hDA7A_0000};
        m[1] = {10'h1, 32'h0000_0200, 32'hDA7A_0001};
        m[2] = {10'h2, 32'h0000_1000, 32'hDA7A_0002};
        m[3] = {10'h3, 32'h0000_0400, 32'hDA7A_0003};
        cli_req_msg     = {m[3], m[2], m[1], m[0]};
        cli_req_opaque  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        cli_req_val     = 4'hF;
        cli_resp_rdy    = 4'hF;
        mem_req_rdy     = 1'b1;
        mem_resp_val    = 1'b0;
        mem_resp_opaque = '0;
        mem_resp_msg    = '0;
        rst             = 1'b1;
        // reset held three cycles with every client requesting
        repeat (3) begin
            tick();
            chk("rst_mem_req_val", mem_req_val_a, 1'b0);
            chk("rst_cli_req_rdy", cli_req_rdy_a, 4'b0000);
        end
        rst = 1'b0;
        #1;
        chk("first_grant", cli_req_rdy_a, 4'b0001);
        // round-robin versus fixed priority with all clients valid
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_val", mem_req_val_a, 1'b1);
            chk("rr_opaque", mem_req_opaque_a, {2'(k % 4), 8'hA0 + 8'(k % 4)});
            chk("rr_msg", mem_req_msg_a, m[k % 4]);
            chk("fp_id", mem_req_opaque_b[9:8], 2'd0);
        end
        // reset mid-operation discards the buffered request
        cli_req_val = 4'h0;
        rst = 1'b1;
        tick();
        chk("midrst_val", mem_req_val_a, 1'b0);
        rst = 1'b0;
        // backpressure with port 2 buffered
        cli_req_opaque = {8'hA3, 8'h33, 8'hA1, 8'hA0};
        cli_req_val = 4'b0100;
        mem_req_rdy = 1'b0;
        #1;
        chk("bp_grant", cli_req_rdy_a, 4'b0100);
        tick();
        cli_req_val = 4'hF;
        #1;
        repeat (5) begin
            chk("bp_val", mem_req_val_a, 1'b1);
            chk("bp_opaque", mem_req_opaque_a, {2'd2, 8'h33});
            chk("bp_msg", mem_req_msg_a, m[2]);
            chk("bp_rdy", cli_req_rdy_a, 4'b0000);
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        chk("bp_resume_rdy", cli_req_rdy_a, 4'b1000);
        exp_opq[0] = {2'd3, 8'hA3};
        exp_opq[1] = {2'd0, 8'hA0};
        exp_opq[2] = {2'd1, 8'hA1};
        exp_opq[3] = {2'd2, 8'h33};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_resume_val", mem_req_val_a, 1'b1);
            chk("bp_resume_opaque", mem_req_opaque_a, exp_opq[k]);
        end
        cli_req_val = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // out-of-order responses with a stalled client
        cli_req_opaque = {8'hA3, 8'hA2, 8'h22, 8'h11};
        cli_req_val = 4'b0001;
        #1;
        chk("ooo_grant0", cli_req_rdy_a, 4'b0001);
        tick();
        cli_req_val = 4'b0010;
        #1;
        chk("ooo_req0", mem_req_opaque_a, {2'd0, 8'h11});
        chk("ooo_grant1", cli_req_rdy_a, 4'b0010);
        tick();
        cli_req_val = 4'b0000;
        #1;
        chk("ooo_req1", mem_req_opaque_a, {2'd1, 8'h22});
        tick();
        mem_resp_val = 1'b1;
        mem_resp_opaque = {2'd1, 8'h22};
        mem_resp_msg = 39'h22_2222_2222;
        cli_resp_rdy = 4'b1101;
        #1;
        chk("stall_mem_rdy", mem_resp_rdy_a, 1'b0);
        chk("stall_resp_val", cli_resp_val_a, 4'b0010);
        tick();
        tick();
        chk("stall_hold", mem_resp_rdy_a, 1'b0);
        cli_resp_rdy = 4'hF;
        #1;
        chk("ooo_p1_mem_rdy", mem_resp_rdy_a, 1'b1);
        chk("ooo_p1_val", cli_resp_val_a, 4'b0010);
        chk("ooo_p1_opaque", cli_resp_opaque_a, 8'h22);
        chk("ooo_p1_msg", cli_resp_msg_a, 39'h22_2222_2222);
        tick();
        mem_resp_opaque = {2'd0, 8'h11};
        mem_resp_msg = 39'h11_1111_1111;
        #1;
        chk("ooo_p0_val", cli_resp_val_a, 4'b0001);
        chk("ooo_p0_opaque", cli_resp_opaque_a, 8'h11);
        chk("ooo_p0_msg", cli_resp_msg_a, 39'h11_1111_1111);
        tick();
        mem_resp_val = 1'b0;
        #1;
        chk("ooo_idle", cli_resp_val_a, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // outstanding limit of two on port 0
        cli_req_opaque = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        cli_req_val = 4'b0001;
        #1;
        chk("lim_grant1", cli_req_rdy_a, 4'b0001);
        tick();
        chk("lim_grant2", cli_req_rdy_a, 4'b0001);
        tick();
        chk("lim_block", cli_req_rdy_a, 4'b0000);
        cli_req_val = 4'b0011;
        #1;
        chk("lim_other_port", cli_req_rdy_a, 4'b0010);
        tick();
        cli_req_val = 4'b0001;
        #1;
        chk("lim_still_blocked", cli_req_rdy_a, 4'b0000);
        mem_resp_val = 1'b1;
        mem_resp_opaque = {2'd0, 8'hA0};
        #1;
        chk("lim_resp_val", cli_resp_val_a, 4'b0001);
        chk("lim_same_cycle", cli_req_rdy_a, 4'b0000);
        tick();
        mem_resp_val = 1'b0;
        #1;
        chk("lim_unmask", cli_req_rdy_a, 4'b0001);
        tick();
        cli_req_val = 4'b0000;
        chk("lim_third_val", mem_req_val_a, 1'b1);
        chk("lim_third_opaque", mem_req_opaque_a, {2'd0, 8'hA0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
